// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and default link parameters
// common to the transmitter and the companion receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 217;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: rd_data shows the word at the
// read pointer whenever empty is low.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts clk_in cycles and flags the last cycle of each
// serial bit; clr holds it at the start of a bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a first-word-fall-through sync FIFO: pops one word
// per frame and shifts it out as start, DATA_BITS data (LSB first), stop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned    BCW      = $clog2(DATA_BITS) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BCW-1:0]       bit_cnt;
  logic                 tick;
  logic                 baud_clr;

  // Holding the timer clear in IDLE makes START last exactly one bit period.
  assign baud_clr = (state == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_in(clk_in),
    .rst   (rst),
    .clr   (baud_clr),
    .tick  (tick)
  );

  assign fifo_rd_en = (state == ST_IDLE) && !fifo_empty && !rst;
  assign busy       = (state != ST_IDLE);
  assign tx_done    = (state == ST_STOP) && tick;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_rd_data;
            bit_cnt   <= '0;
            tx        <= 1'b0;
            state     <= ST_START;
          end else begin
            tx <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          // tx is registered, so each tick presents the next bit one edge ahead
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + BCW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx behind a real sync_fifo: stimulus queues expected
// bytes, a serial-line monitor decodes frames and checks them in order.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int unsigned DB  = 8;
  localparam int unsigned CPB = 4;

  logic          clk_in   = 1'b0;
  logic          rst      = 1'b1;
  logic          fifo_rst = 1'b1;
  logic          wr_en    = 1'b0;
  logic [DB-1:0] wr_data  = '0;
  logic          fifo_empty, fifo_full, fifo_rd_en, tx, busy, tx_done;
  logic [DB-1:0] fifo_rd_data;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  logic [DB-1:0] exp_q [$];
  int unsigned   starts [$];
  int rd_cnt = 0, done_cnt = 0, busy_cnt = 0, viol = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  sync_fifo #(.WIDTH(DB), .DEPTH(1024)) u_fifo (
    .clk_in (clk_in),
    .rst    (fifo_rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (fifo_rd_en),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  fifo_uart_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [DB-1:0] b, input logic sb);
    wr_en   = 1'b1;
    wr_data = b;
    if (sb) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_rd(input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (fifo_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    check("rd_en_seen", ok, 1);
  endtask

  task automatic drain(input int lim);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1);
  endtask

  task automatic mwait(input int n, inout logic ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (rst) ab = 1'b1;
    end
  endtask

  always @(negedge clk_in) begin
    if (fifo_rd_en) rd_cnt++;
    if (tx_done) done_cnt++;
    if (busy) busy_cnt++;
    if (fifo_rd_en && (fifo_empty || busy)) viol++;
  end

  // Frame decoder: samples the middle of every bit after a falling edge on tx.
  initial begin : monitor
    logic          prev_tx;
    logic          ab;
    logic [DB-1:0] d;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk_in);
      if (!rst && prev_tx === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        ab = 1'b0;
        d  = '0;
        mwait(1, ab);
        if (!ab) check("start_bit", tx, 0);
        for (int i = 0; i < DB; i++) begin
          if (ab) break;
          mwait(CPB, ab);
          d[i] = tx;
        end
        if (!ab) mwait(CPB, ab);
        if (!ab) begin
          check("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0h want none", d);
          end else begin
            check("frame_data", d, exp_q.pop_front());
          end
        end
      end
      prev_tx = tx;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int rd0, done0, busy0, s0;
    logic [39:0] wave, exp_wave, dn, exp_dn;
    logic [DB-1:0] pat;
    int unsigned b;
    int errs;

    // Reset state, and no pop while rst is held even with data waiting
    repeat (3) tick();
    @(negedge clk_in);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    tick();
    fifo_rst = 1'b0;
    tick();
    push(8'hA5, 1'b1);
    @(negedge clk_in);
    check("rst_fifo_nonempty", fifo_empty, 0);
    check("rst_no_pop", fifo_rd_en, 0);

    // Single frame 0xA5: exact line waveform and strobes
    tick();
    rd0 = rd_cnt; done0 = done_cnt; busy0 = busy_cnt;
    rst = 1'b0;
    wait_rd(10);
    pat = 8'hA5;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk_in);
      wave[j-1] = tx;
      dn[j-1]   = tx_done;
      b = (j - 1) / CPB;
      if (b == 0) exp_wave[j-1] = 1'b0;
      else if (b <= DB) exp_wave[j-1] = pat[b-1];
      else exp_wave[j-1] = 1'b1;
      exp_dn[j-1] = (j == 40);
    end
    check("a5_wave", wave, exp_wave);
    check("a5_done_pos", dn, exp_dn);
    drain(20);
    repeat (5) tick();
    check("a5_pops", rd_cnt - rd0, 1);
    check("a5_done_cnt", done_cnt - done0, 1);
    check("a5_busy_cycles", busy_cnt - busy0, 40);

    // Back-to-back 0x00, 0xFF, 0x3C
    rd0 = rd_cnt; s0 = starts.size();
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    drain(3 * 41 + 50);
    tick();
    check("b2b_pops", rd_cnt - rd0, 3);
    check("b2b_empty", fifo_empty, 1);
    check("b2b_frames", starts.size() - s0, 3);
    if (starts.size() == s0 + 3) begin
      check("b2b_gap1", starts[s0+1] - starts[s0], 41);
      check("b2b_gap2", starts[s0+2] - starts[s0+1], 41);
    end

    // Idle with empty FIFO
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) errs++;
    end
    check("idle_100", errs, 0);

    // Reset during data bit 3 of 0x5A aborts the frame
    tick();
    rd0 = rd_cnt; done0 = done_cnt;
    push(8'h5A, 1'b0);
    wait_rd(10);
    repeat (17) @(negedge clk_in);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk_in);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    repeat (60) tick();
    check("abort_no_done", done_cnt - done0, 0);
    check("abort_pops", rd_cnt - rd0, 1);
    push(8'h81, 1'b1);
    drain(100);

    // Fill to full while held in reset, then drain all 1024 words
    tick();
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) push(8'(i), 1'b1);
    @(negedge clk_in);
    check("fill_full", fifo_full, 1);
    tick();
    rst = 1'b0;
    wait_rd(10);
    @(negedge clk_in);
    check("full_after_pop", fifo_full, 0);
    drain(1024 * 41 + 100);

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("rd_en_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8: width of each FIFO word and of each serial frame's data field.
REQ-002 Parameter CLKS_PER_BIT, default 217: clk_in cycles per serial bit (25 MHz / 115200 baud); legal range >= 2.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_empty  input  1  read-side empty flag of the upstream sync FIFO.
REQ-006 fifo_rd_data  input  DATA_BITS  read-side data of the FIFO; valid whenever fifo_empty=0 (word at the read pointer, no read latency).
REQ-007 fifo_rd_en  output  1  pop strobe to the FIFO; one cycle per word consumed.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-010 tx_done  output  1  single-cycle pulse on the last cycle of each stop bit.

Function
REQ-011 States SHALL be IDLE, START, DATA, STOP.
REQ-012 fifo_rd_en SHALL equal (state==IDLE && fifo_empty==0 && rst==0), combinational from registered state, so that word capture and FIFO pop happen on the same edge.
REQ-013 IDLE: if fifo_empty=0, then on the next edge fifo_rd_data SHALL load the shift register, the bit counter SHALL clear, the baud counter SHALL clear, state SHALL go to START and tx SHALL go 0; otherwise stay in IDLE with tx=1.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA: DATA_BITS bits, LSB first, each held exactly CLKS_PER_BIT cycles; after bit DATA_BITS-1 go to STOP.
REQ-016 STOP: tx=1 for exactly CLKS_PER_BIT cycles; tx_done=1 on the final cycle; then go to IDLE.
REQ-017 Frame period SHALL be 1 IDLE cycle + (DATA_BITS+2)*CLKS_PER_BIT cycles, including back-to-back frames from a non-empty FIFO.
REQ-018 Baud counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL wrap at CLKS_PER_BIT-1 without overflow. The bit counter width SHALL be $clog2(DATA_BITS)+1.
REQ-019 fifo_rd_en SHALL never be asserted outside IDLE and never while fifo_empty=1.
REQ-020 Changes on fifo_empty or fifo_rd_data during START, DATA or STOP SHALL have no effect on the current frame.
REQ-021 A word arriving on the same cycle the FIFO leaves empty (IDLE, fifo_empty falls) SHALL be popped on the following edge.

Reset
REQ-022 While rst=1 at an edge: state=IDLE, tx=1, busy=0, tx_done=0, all counters=0, and the shift register=0.
REQ-023 fifo_rd_en SHALL be 0 while rst=1.
REQ-024 Reset mid-frame SHALL abort the frame: tx=1 from the next edge, no pop, no tx_done. The aborted word is lost.

Structure
REQ-025 Package uart_pkg SHALL hold the state enumeration and the default CLKS_PER_BIT/DATA_BITS constants shared with the companion UART receiver.
REQ-026 The baud counter SHALL be a sub-module uart_baud_tick (parameter CLKS_PER_BIT; inputs clk_in, rst, clr; output tick on the last cycle of each bit period). All other logic SHALL be in fifo_uart_tx.

Verification (DATA_BITS=8, CLKS_PER_BIT=4, driven by a real sync_fifo instance)
REQ-027 Push 0xA5 into an empty FIFO -> one fifo_rd_en pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; tx_done once; busy high for 40 cycles.
REQ-028 Push 0x00, 0xFF, 0x3C back-to-back -> three frames, each 41 cycles apart start-to-start; three fifo_rd_en pulses; FIFO empty after the third pop; the decoded bytes match in order.
REQ-029 FIFO held empty for 100 cycles -> tx=1, busy=0, fifo_rd_en=0 throughout.
REQ-030 Assert rst for 1 cycle during DATA bit 3 of 0x5A -> tx=1 and busy=0 from the next edge, with no tx_done. A following push of 0x81 transmits correctly.
REQ-031 Fill the FIFO to full (1024 words, incrementing pattern) -> all 1024 bytes are transmitted in order, full deasserts after the first pop, and no pop occurs while empty.
